// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared types and constants for the router datapath and control blocks.
//   port_id_t      : 3-bit router port identifier
//   LOCAL..WEST    : port-ID encoding shared with the XY port decoder
//   alloc_state_e  : per-output allocation state (IDLE / LOCKED)
// -----------------------------------------------------------------------------
package noc_pkg;

  typedef logic [2:0] port_id_t;

  localparam port_id_t LOCAL = 3'd0;
  localparam port_id_t NORTH = 3'd1;
  localparam port_id_t SOUTH = 3'd2;
  localparam port_id_t EAST  = 3'd3;
  localparam port_id_t WEST  = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage : noc_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first asserted request found
// scanning upward from ptr with wrap-around.
//   req       (in)  : request vector, one bit per requester
//   ptr       (in)  : highest-priority requester index (must be < NUM_REQ)
//   gnt_valid (out) : at least one request was asserted
//   gnt_idx   (out) : index of the winning requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Rotating priority scan starting at the pointer
  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Wormhole output-port allocator. Head flits compete round-robin for their
// requested output; the winner owns the output until its tail flit crosses.
//   clk, rst_n   (in)  : clock, synchronous active-low reset
//   req_valid    (in)  : input i has a flit at its buffer head
//   req_head     (in)  : that flit is a head flit
//   req_tail     (in)  : that flit is a tail flit
//   req_port     (in)  : requested output for input i (packed, PORT_ID_W each)
//   out_ready    (in)  : output j's downstream can take a flit
//   grant        (out) : input i's flit crosses the crossbar (buffer pops)
//   out_valid    (out) : output j carries a flit
//   out_sel      (out) : crossbar select of output j (owning input ID)
//   err_bad_port (out) : a head flit requests a non-existent output
// -----------------------------------------------------------------------------
module switch_allocator
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int PORT_ID_W = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS-1:0]           req_head,
  input  logic [NUM_PORTS-1:0]           req_tail,
  input  logic [NUM_PORTS*PORT_ID_W-1:0] req_port,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*PORT_ID_W-1:0] out_sel,
  output logic                           err_bad_port
);

  localparam logic [PORT_ID_W-1:0] NUM_ID  = PORT_ID_W'(NUM_PORTS);
  localparam logic [PORT_ID_W-1:0] LAST_ID = PORT_ID_W'(NUM_PORTS - 1);

  // After a release the input just served drops to lowest priority.
  function automatic logic [PORT_ID_W-1:0] next_ptr(input logic [PORT_ID_W-1:0] owner);
    logic [PORT_ID_W-1:0] nxt;
    if (owner == LAST_ID) begin
      nxt = '0;
    end else begin
      nxt = owner + PORT_ID_W'(1);
    end
    return nxt;
  endfunction

  logic [PORT_ID_W-1:0]           req_port_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]           arb_req_s  [NUM_PORTS];
  logic [NUM_PORTS-1:0]           arb_valid_s;
  logic [PORT_ID_W-1:0]           arb_idx_s  [NUM_PORTS];
  logic [NUM_PORTS-1:0]           bad_s;
  logic [NUM_PORTS-1:0]           grant_s;
  logic [NUM_PORTS-1:0]           out_valid_s;
  logic [NUM_PORTS-1:0]           release_s;
  logic [NUM_PORTS*PORT_ID_W-1:0] out_sel_s;

  alloc_state_e                   state_r    [NUM_PORTS];
  logic [PORT_ID_W-1:0]           owner_r    [NUM_PORTS];
  logic [PORT_ID_W-1:0]           ptr_r      [NUM_PORTS];
  logic [NUM_PORTS-1:0]           in_busy_r;

  // Route unpacking, bad-route detection and per-output request vectors
  always_comb begin
    req_port_s = '{default: '0};
    arb_req_s  = '{default: '0};
    bad_s      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_port_s[i] = req_port[i*PORT_ID_W +: PORT_ID_W];
      bad_s[i]      = req_valid[i] && req_head[i] && (req_port_s[i] >= NUM_ID);
    end
    // A busy input is already mid-packet; its head bit cannot start a new lock.
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_req_s[j][i] = req_valid[i] && req_head[i] && !in_busy_r[i] &&
                          (req_port_s[i] == PORT_ID_W'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arbiter #(
      .NUM_REQ (NUM_PORTS),
      .IDX_W   (PORT_ID_W)
    ) u_arb (
      .req       (arb_req_s[j]),
      .ptr       (ptr_r[j]),
      .gnt_valid (arb_valid_s[j]),
      .gnt_idx   (arb_idx_s[j])
    );
  end

  // Crossbar select, grant and release decode for locked outputs
  always_comb begin
    grant_s     = '0;
    out_valid_s = '0;
    release_s   = '0;
    out_sel_s   = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (state_r[j] == LOCKED) begin
        // Select follows the owner even while stalled, so the lock is visible.
        out_sel_s[j*PORT_ID_W +: PORT_ID_W] = owner_r[j];
        if (req_valid[owner_r[j]] && out_ready[j]) begin
          grant_s[owner_r[j]] = 1'b1;
          out_valid_s[j]      = 1'b1;
          release_s[j]        = req_tail[owner_r[j]];
        end else begin
          out_valid_s[j] = 1'b0;
        end
      end else begin
        out_sel_s[j*PORT_ID_W +: PORT_ID_W] = '0;
      end
    end
  end

  // Per-output lock state, round-robin pointers and input busy flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_r[j] <= IDLE;
        owner_r[j] <= '0;
        ptr_r[j]   <= '0;
      end
      in_busy_r <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        case (state_r[j])
          IDLE: begin
            // Allocation cycle: no grant yet, lock takes effect next cycle.
            if (arb_valid_s[j]) begin
              state_r[j]              <= LOCKED;
              owner_r[j]              <= arb_idx_s[j];
              in_busy_r[arb_idx_s[j]] <= 1'b1;
            end
          end
          LOCKED: begin
            if (release_s[j]) begin
              state_r[j]            <= IDLE;
              owner_r[j]            <= '0;
              in_busy_r[owner_r[j]] <= 1'b0;
              ptr_r[j]              <= next_ptr(owner_r[j]);
            end
          end
          default: begin
            state_r[j] <= IDLE;
            owner_r[j] <= '0;
          end
        endcase
      end
    end
  end

  assign grant        = grant_s;
  assign out_valid    = out_valid_s;
  assign out_sel      = out_sel_s;
  assign err_bad_port = |bad_s;

endmodule : switch_allocator

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [4:0]  req_head;
  logic [4:0]  req_tail;
  logic [14:0] req_port;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic        err_bad_port;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  grant;
    logic [4:0]  ov;
    logic [14:0] sel;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  switch_allocator #(.NUM_PORTS(5), .PORT_ID_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_head     (req_head),
    .req_tail     (req_tail),
    .req_port     (req_port),
    .out_ready    (out_ready),
    .grant        (grant),
    .out_valid    (out_valid),
    .out_sel      (out_sel),
    .err_bad_port (err_bad_port)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] sel(input int j, input logic [2:0] o);
    logic [14:0] v;
    v = 15'd0;
    v[j*3 +: 3] = o;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic h, input logic t, input logic [2:0] p);
    req_valid[i]     = 1'b1;
    req_head[i]      = h;
    req_tail[i]      = t;
    req_port[i*3 +: 3] = p;
  endtask

  task automatic drop_req(input int i);
    req_valid[i]     = 1'b0;
    req_head[i]      = 1'b0;
    req_tail[i]      = 1'b0;
    req_port[i*3 +: 3] = 3'd0;
  endtask

  task automatic clear_all();
    req_valid = 5'd0;
    req_head  = 5'd0;
    req_tail  = 5'd0;
    req_port  = 15'd0;
    out_ready = 5'b11111;
  endtask

  // Push the expectation for the current cycle, then compare mid-cycle.
  task automatic cyc(input logic [4:0] g, input logic [4:0] ov, input logic [14:0] s,
                     input logic err, input string tag);
    exp_t e;
    e.grant = g; e.ov = ov; e.sel = s; e.err = err; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".grant"},     {10'd0, grant},        {10'd0, e.grant});
      chk({e.tag, ".out_valid"}, {10'd0, out_valid},    {10'd0, e.ov});
      chk({e.tag, ".out_sel"},   out_sel,               e.sel);
      chk({e.tag, ".err"},       {14'd0, err_bad_port}, {14'd0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "reset_idle");

    // Basic wormhole: input 0 -> EAST, head + 3 body + tail
    set_req(0, 1'b1, 1'b0, EAST);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "wh_alloc");
    cyc(5'b00001, 5'b01000, sel(3, 3'd0), 1'b0, "wh_head");
    set_req(0, 1'b0, 1'b0, EAST);
    for (int k = 0; k < 3; k++) cyc(5'b00001, 5'b01000, sel(3, 3'd0), 1'b0, "wh_body");
    set_req(0, 1'b0, 1'b1, EAST);
    cyc(5'b00001, 5'b01000, sel(3, 3'd0), 1'b0, "wh_tail");
    drop_req(0);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "wh_idle");

    // Contention on LOCAL: single-flit packets from 1, 2, 4 held continuously
    set_req(1, 1'b1, 1'b1, LOCAL);
    set_req(2, 1'b1, 1'b1, LOCAL);
    set_req(4, 1'b1, 1'b1, LOCAL);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rr_alloc1");
    cyc(5'b00010, 5'b00001, sel(0, 3'd1), 1'b0, "rr_grant1");
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rr_alloc2");
    cyc(5'b00100, 5'b00001, sel(0, 3'd2), 1'b0, "rr_grant2");
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rr_alloc3");
    cyc(5'b10000, 5'b00001, sel(0, 3'd4), 1'b0, "rr_grant4");
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rr_alloc4");
    cyc(5'b00010, 5'b00001, sel(0, 3'd1), 1'b0, "rr_grant1_again");
    clear_all();
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rr_idle");

    // Backpressure and bubble on NORTH with input 4 waiting
    set_req(3, 1'b1, 1'b0, NORTH);
    set_req(4, 1'b1, 1'b1, NORTH);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "bp_alloc");
    cyc(5'b01000, 5'b00010, sel(1, 3'd3), 1'b0, "bp_flit1");
    set_req(3, 1'b0, 1'b0, NORTH);
    out_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) cyc(5'd0, 5'd0, sel(1, 3'd3), 1'b0, "bp_stall");
    out_ready[1] = 1'b1;
    cyc(5'b01000, 5'b00010, sel(1, 3'd3), 1'b0, "bp_flit2");
    drop_req(3);
    cyc(5'd0, 5'd0, sel(1, 3'd3), 1'b0, "bp_bubble");
    set_req(3, 1'b0, 1'b0, NORTH);
    cyc(5'b01000, 5'b00010, sel(1, 3'd3), 1'b0, "bp_flit3");
    set_req(3, 1'b0, 1'b1, NORTH);
    cyc(5'b01000, 5'b00010, sel(1, 3'd3), 1'b0, "bp_tail");
    drop_req(3);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "bp_alloc_next");
    cyc(5'b10000, 5'b00010, sel(1, 3'd4), 1'b0, "bp_next_grant");
    drop_req(4);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "bp_idle");

    // Parallel outputs: 0 -> EAST and 2 -> WEST together
    set_req(0, 1'b1, 1'b0, EAST);
    set_req(2, 1'b1, 1'b0, WEST);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "par_alloc");
    cyc(5'b00101, 5'b11000, sel(3, 3'd0) | sel(4, 3'd2), 1'b0, "par_head");
    set_req(0, 1'b0, 1'b1, EAST);
    set_req(2, 1'b0, 1'b1, WEST);
    cyc(5'b00101, 5'b11000, sel(3, 3'd0) | sel(4, 3'd2), 1'b0, "par_tail");
    clear_all();
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "par_idle");

    // Bad routes
    set_req(1, 1'b1, 1'b0, 3'd6);
    cyc(5'd0, 5'd0, 15'd0, 1'b1, "bad_port6");
    cyc(5'd0, 5'd0, 15'd0, 1'b1, "bad_port6_hold");
    set_req(1, 1'b1, 1'b1, 3'd5);
    cyc(5'd0, 5'd0, 15'd0, 1'b1, "bad_port5");
    set_req(1, 1'b0, 1'b0, 3'd6);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "bad_nonhead");
    clear_all();
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "bad_clear");

    // Reset in the middle of a packet on SOUTH
    set_req(3, 1'b1, 1'b0, SOUTH);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rst_alloc");
    cyc(5'b01000, 5'b00100, sel(2, 3'd3), 1'b0, "rst_head");
    clear_all();
    rst_n = 1'b0;
    cyc(5'd0, 5'd0, sel(2, 3'd3), 1'b0, "rst_cycle");
    rst_n = 1'b1;
    set_req(3, 1'b1, 1'b1, SOUTH);
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rst_abandon");
    cyc(5'b01000, 5'b00100, sel(2, 3'd3), 1'b0, "rst_new_grant");
    clear_all();
    cyc(5'd0, 5'd0, 15'd0, 1'b0, "rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_switch_allocator

// File: doc/switch_allocator.md
# switch_allocator

Per-router output-port allocator for wormhole switching. It takes each input port's head-flit route (the 3-bit output port ID from that input's XY port decoder) and arbitrates round-robin among inputs contending for the same output. It then locks the output to the winner until that packet's tail flit passes, and drives the crossbar selects and per-input pop grants. It sits between the input buffers/port decoders and the 5x5 crossbar in every router.

## Interface
- `NUM_PORTS`, default 5: number of router ports. Inputs and outputs are both indexed by port ID.
- `PORT_ID_W`, default 3: width of a port ID.
- `clk` (in, 1): the single clock; all state updates on the rising edge.
- `rst_n` (in, 1): reset, synchronous, active-low.
- `req_valid` (in, NUM_PORTS): input i has a flit at its buffer head.
- `req_head` (in, NUM_PORTS): the flit at input i is a head flit.
- `req_tail` (in, NUM_PORTS): the flit at input i is a tail flit. Head and tail both high means a single-flit packet.
- `req_port` (in, NUM_PORTS*PORT_ID_W): requested output port for input i. Meaningful only when `req_valid[i] && req_head[i]`.
- `out_ready` (in, NUM_PORTS): output j's downstream can accept a flit this cycle.
- `grant` (out, NUM_PORTS): the flit at input i crosses the crossbar this cycle; the input buffer pops it.
- `out_valid` (out, NUM_PORTS): output j carries a flit this cycle.
- `out_sel` (out, NUM_PORTS*PORT_ID_W): crossbar select for output j, the ID of the owning input.
- `err_bad_port` (out, 1): one-cycle pulse when any head flit requests a port ID ≥ NUM_PORTS.

## Operation
- State per output j: `IDLE` or `LOCKED(owner)`. Also keep an RR pointer `ptr[j]` (the highest-priority input) and a per-input flag `in_busy[i]`.
- Eligible requester for output j: any i with `req_valid[i] && req_head[i] && !in_busy[i] && req_port[i]==j`.
- IDLE with at least one eligible requester:
  - Pick the first eligible i scanning upward from `ptr[j]`, with wrap-around.
  - Next edge: go to `LOCKED(i)` and set `in_busy[i]`.
  - No grant is issued in the allocation cycle.
- Across different outputs, one input can win at most one output. An input is eligible for exactly one output per cycle, so this holds by construction.
- In `LOCKED(o)`:
  - `grant[o] = req_valid[o] && out_ready[j]`, `out_valid[j] = grant[o]`, `out_sel[j] = o`. These are combinational from state and inputs.
- Release: when `grant[o] && req_tail[o]`, on the next edge:
  - output j goes to IDLE;
  - `in_busy[o]` clears;
  - `ptr[j]` becomes (o+1) mod NUM_PORTS.
- The pointer changes only on release.
- Bad route: a head flit with `req_port ≥ NUM_PORTS` is never granted and pulses `err_bad_port` every cycle it is presented. That input stalls; the fault is a system error and is not recovered here.
- Stalls:
  - If `out_ready[j]` is low, the lock holds and `grant` stays low.
  - If `req_valid[o]` is low mid-packet (a bubble), the lock holds.
- U-turns (i==j) are permitted. Only XY legality, enforced upstream, constrains routes.
- Outputs when not locked: `out_sel[j]` = 0 and `out_valid[j]` = 0.

## Timing
- Reset (`rst_n` low at an edge):
  - all outputs IDLE, all `ptr` = 0, all `in_busy` = 0;
  - `grant`, `out_valid`, `out_sel` and `err_bad_port` read 0 from the following cycle.
- Reset mid-packet abandons the lock. The input buffers are reset by the same `rst_n`.
- Latency: head presented in cycle N with output j IDLE gives the earliest grant in cycle N+1.
- Body flits: one per cycle at full throughput while `out_ready` is high.
- Back-to-back packets on one output:
  - tail granted in cycle T, IDLE in T+1 (allocation cycle), next head granted in T+2;
  - one bubble per packet boundary.
- Single-flit packet: allocated in N, granted and released in N+1, output IDLE in N+2.
- Simultaneous events in the same cycle, output j releasing from input a while input b's head requests j: b does not win this cycle because j is still LOCKED; b is considered in the IDLE cycle with the updated `ptr`.
- `err_bad_port` is combinational from the inputs, same cycle.

## Structure
- Shared package `noc_pkg`:
  - port-ID constants LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4, matching the existing port-ID defines;
  - `port_id_t` (logic [2:0]);
  - `alloc_state_e` {IDLE, LOCKED}.
- Sub-module `rr_arbiter #(NUM_REQ)`: a combinational one-hot/index pick from a request vector and a pointer. It is instantiated once per output.
- Lock state, pointers, `in_busy` and grant/select muxing live in `switch_allocator`.

## Test plan
- Reset, then idle: `rst_n`=0 for 2 cycles, no requests. All outputs read 0, `ptr` all 0.
- Basic wormhole: input 0 head→port 3 (EAST) at cycle 1, 3 body flits, then tail, `out_ready` high.
  - `grant[0]` in cycles 2–6;
  - `out_sel[3]` = 0 throughout;
  - output 3 IDLE in cycle 7.
- Contention and RR: inputs 1, 2, 4 all head→port 0 (LOCAL) with single-flit packets, held continuously.
  - Grant order is 1, 2, 4, then 1 again when re-presented.
  - Each grant is 2 cycles apart.
- Backpressure: locked 4-flit packet with `out_ready[j]` low for cycles 3–5.
  - `grant` stays low in those cycles with the lock held;
  - the flits complete after `out_ready` returns;
  - no other input is granted output j meanwhile.
- Parallel outputs: input 0→EAST and input 2→WEST heads in the same cycle. Both are allocated in the same cycle and granted concurrently.
- Bad port and reset mid-packet:
  - head with `req_port`=6 gives `err_bad_port`=1 and no grant;
  - `rst_n` low during a locked packet leaves all outputs IDLE, and a new head is granted 2 cycles after release of reset.
